// File: rtl/sevenseg_scan_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module : sevenseg_scan_ctrl_pkg
// Brief  : Shared FSM state encodings, anode lookup and blanking helper.
// Rev    : 1.0
// ============================================================================
package sevenseg_scan_ctrl_pkg;

  typedef enum logic [0:0] {
    ST_BLANK = 1'b0,
    ST_DWELL = 1'b1
  } state_t;

  // One-cold anode patterns, digit 0 in the low nibble.
  localparam logic [15:0] c_an_lut = {4'b0111, 4'b1011, 4'b1101, 4'b1110};
  localparam logic [3:0]  c_an_off = 4'b1111;

  function automatic logic [3:0] an_onecold(input logic [1:0] idx);
    return c_an_lut[{idx, 2'b00} +: 4];
  endfunction

  // A digit is a leading zero if it and every more-significant digit are zero.
  function automatic logic lz_blank(input logic [15:0] v, input logic [1:0] idx);
    logic r;
    case (idx)
      2'd3:    r = (v[15:12] == 4'h0);
      2'd2:    r = (v[15:8]  == 8'h00);
      2'd1:    r = (v[15:4]  == 12'h000);
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sevenseg_scan_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module : sevenseg_scan_ctrl_if
// Brief  : Load/display bundle between a host and the scan controller.
// Rev    : 1.0
// ============================================================================
interface sevenseg_scan_ctrl_if;
  logic        load;
  logic [15:0] value;
  logic [3:0]  dp_in;
  logic        lz_en;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_tick;

  modport master (
    output load, value, dp_in, lz_en,
    input  an, seg, dp, frame_tick
  );

  modport slave (
    input  load, value, dp_in, lz_en,
    output an, seg, dp, frame_tick
  );
endinterface
`default_nettype wire

// File: rtl/sevenseg_scan_ctrl_sevensegment.sv
`default_nettype none
// ============================================================================
// Module : sevensegment
// Brief  : Hex nibble to active-high segments, seg[6:0] = {g,f,e,d,c,b,a}.
// Rev    : 1.0
// ============================================================================
module sevensegment (
  input  wire logic [3:0] wxyz,
  output logic      [6:0] seg
);
  always_comb begin
    seg = 7'h00;
    case (wxyz)
      4'h0: seg = 7'h3F;
      4'h1: seg = 7'h06;
      4'h2: seg = 7'h5B;
      4'h3: seg = 7'h4F;
      4'h4: seg = 7'h66;
      4'h5: seg = 7'h6D;
      4'h6: seg = 7'h7D;
      4'h7: seg = 7'h07;
      4'h8: seg = 7'h7F;
      4'h9: seg = 7'h6F;
      4'hA: seg = 7'h77;
      4'hB: seg = 7'h7C;
      4'hC: seg = 7'h39;
      4'hD: seg = 7'h5E;
      4'hE: seg = 7'h79;
      4'hF: seg = 7'h71;
      default: seg = 7'h00;
    endcase
  end
endmodule
`default_nettype wire

// File: rtl/sevenseg_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module : sevenseg_scan_ctrl
// Brief  : Four-digit multiplexed seven-segment scanner with frame-synchronous update.
// Rev    : 1.0
// ============================================================================
module sevenseg_scan_ctrl
  import sevenseg_scan_ctrl_pkg::*;
#(
  parameter logic [15:0] DWELL_CYC = 16'd50000,
  parameter logic [7:0]  BLANK_CYC = 8'd8
) (
  input  wire logic       clk,
  input  wire logic       rst_n,
  sevenseg_scan_ctrl_if.slave bus
);

  localparam logic [15:0] c_dwell_last = DWELL_CYC - 16'd1;
  localparam logic [15:0] c_blank_last = {8'd0, BLANK_CYC} - 16'd1;

  state_t      r_state, w_nxt_state;
  logic [1:0]  r_idx, w_nxt_idx;
  logic [15:0] r_cnt, w_nxt_cnt;
  logic        w_wrap;

  logic [15:0] r_disp_val, r_pend_val;
  logic [3:0]  r_disp_dp, r_pend_dp;
  logic        r_pend_vld;

  logic [3:0]  r_an;
  logic [3:0]  r_nib;
  logic        r_segen;
  logic        r_dp;
  logic        r_tick;
  logic [6:0]  w_dec_seg;

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_idx   = r_idx;
    w_nxt_cnt   = r_cnt + 16'd1;
    w_wrap      = 1'b0;
    case (r_state)
      ST_BLANK: begin
        if (r_cnt == c_blank_last) begin
          w_nxt_state = ST_DWELL;
          w_nxt_cnt   = 16'd0;
        end
      end
      ST_DWELL: begin
        if (r_cnt == c_dwell_last) begin
          w_nxt_state = ST_BLANK;
          w_nxt_idx   = r_idx + 2'd1;
          w_nxt_cnt   = 16'd0;
          w_wrap      = (r_idx == 2'd3);
        end
      end
      default: begin
        w_nxt_state = ST_BLANK;
        w_nxt_cnt   = 16'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_BLANK;
      r_idx   <= 2'd0;
      r_cnt   <= 16'd0;
    end else begin
      r_state <= w_nxt_state;
      r_idx   <= w_nxt_idx;
      r_cnt   <= w_nxt_cnt;
    end
  end

  // A load landing on the wrap edge bypasses the pending stage entirely.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_disp_val <= 16'd0;
      r_disp_dp  <= 4'd0;
      r_pend_val <= 16'd0;
      r_pend_dp  <= 4'd0;
      r_pend_vld <= 1'b0;
    end else if (bus.load) begin
      if (w_wrap) begin
        r_disp_val <= bus.value;
        r_disp_dp  <= bus.dp_in;
        r_pend_vld <= 1'b0;
      end else begin
        r_pend_val <= bus.value;
        r_pend_dp  <= bus.dp_in;
        r_pend_vld <= 1'b1;
      end
    end else if (w_wrap && r_pend_vld) begin
      r_disp_val <= r_pend_val;
      r_disp_dp  <= r_pend_dp;
      r_pend_vld <= 1'b0;
    end
  end

  logic [3:0] w_dig_nib;
  logic       w_dig_dp;
  logic       w_blank;

  assign w_dig_nib = r_disp_val[{w_nxt_idx, 2'b00} +: 4];
  assign w_dig_dp  = r_disp_dp[w_nxt_idx];
  assign w_blank   = bus.lz_en & lz_blank(r_disp_val, w_nxt_idx);

  // Outputs are computed from the next state so they move with the FSM edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_an    <= c_an_off;
      r_nib   <= 4'd0;
      r_segen <= 1'b0;
      r_dp    <= 1'b0;
      r_tick  <= 1'b0;
    end else begin
      r_tick <= w_wrap;
      r_nib  <= w_dig_nib;
      if (w_nxt_state == ST_DWELL) begin
        r_an    <= (w_blank && !w_dig_dp) ? c_an_off : an_onecold(w_nxt_idx);
        r_segen <= ~w_blank;
        r_dp    <= w_dig_dp;
      end else begin
        r_an    <= c_an_off;
        r_segen <= 1'b0;
        r_dp    <= 1'b0;
      end
    end
  end

  sevensegment u_dec (
    .wxyz (r_nib),
    .seg  (w_dec_seg)
  );

  assign bus.an         = r_an;
  assign bus.seg        = r_segen ? w_dec_seg : 7'd0;
  assign bus.dp         = r_dp;
  assign bus.frame_tick = r_tick;

endmodule
`default_nettype wire

// File: tb/tb_sevenseg_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_sevenseg_scan_ctrl
// Brief  : Directed frame-by-frame check of scan timing, update and blanking.
// Rev    : 1.0
// ============================================================================
module tb_sevenseg_scan_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  int   n_chk = 0;
  int   n_err = 0;

  sevenseg_scan_ctrl_if bus();

  sevenseg_scan_ctrl #(
    .DWELL_CYC (16'd4),
    .BLANK_CYC (8'd2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Checks nph cycles of one 24-cycle frame starting at phase 0 (first BLANK cycle).
  // segs = {d3,d2,d1,d0}, anlo = digits whose anode goes low.
  task automatic run_frame(input string tag, input int nph, input logic tick_exp,
                           input logic lz, input logic [27:0] segs,
                           input logic [3:0] anlo, input logic [3:0] dps,
                           input int ld_a, input logic [15:0] va,
                           input int ld_b, input logic [15:0] vb,
                           input logic [3:0] dpv);
    bus.lz_en = lz;
    for (int ph = 0; ph < nph; ph++) begin
      int slot = ph / 6;
      int off  = ph % 6;
      logic [3:0] e_an  = 4'b1111;
      logic [6:0] e_seg = 7'd0;
      logic       e_dp  = 1'b0;
      if (off >= 2) begin
        e_an  = anlo[slot] ? ~(4'b0001 << slot) : 4'b1111;
        e_seg = segs[slot*7 +: 7];
        e_dp  = dps[slot];
      end
      chk($sformatf("%s an ph%0d", tag, ph),   32'(bus.an),  32'(e_an));
      chk($sformatf("%s seg ph%0d", tag, ph),  32'(bus.seg), 32'(e_seg));
      chk($sformatf("%s dp ph%0d", tag, ph),   32'(bus.dp),  32'(e_dp));
      chk($sformatf("%s tick ph%0d", tag, ph), 32'(bus.frame_tick),
          32'((ph == 0) ? tick_exp : 1'b0));
      if (ph == ld_a) begin
        bus.load = 1'b1; bus.value = va; bus.dp_in = dpv;
      end else if (ph == ld_b) begin
        bus.load = 1'b1; bus.value = vb; bus.dp_in = dpv;
      end else begin
        bus.load = 1'b0;
      end
      step();
    end
  endtask

  localparam logic [27:0] c_s0000 = {7'h3F, 7'h3F, 7'h3F, 7'h3F};
  localparam logic [27:0] c_s12af = {7'h06, 7'h5B, 7'h77, 7'h71};
  localparam logic [27:0] c_s7lz  = {7'h00, 7'h00, 7'h00, 7'h07};
  localparam logic [27:0] c_s0007 = {7'h3F, 7'h3F, 7'h3F, 7'h07};
  localparam logic [27:0] c_s8888 = {7'h7F, 7'h7F, 7'h7F, 7'h7F};
  localparam logic [27:0] c_s0lz  = {7'h00, 7'h00, 7'h00, 7'h3F};

  initial begin
    rst_n     = 1'b0;
    bus.load  = 1'b0;
    bus.value = 16'd0;
    bus.dp_in = 4'd0;
    bus.lz_en = 1'b0;
    repeat (3) step();
    chk("reset an",   32'(bus.an),         32'h0000000F);
    chk("reset seg",  32'(bus.seg),        32'h00000000);
    chk("reset dp",   32'(bus.dp),         32'h00000000);
    chk("reset tick", 32'(bus.frame_tick), 32'h00000000);
    rst_n = 1'b1;

    run_frame("f0_zero",   24, 1'b0, 1'b0, c_s0000, 4'b1111, 4'b0000, 10, 16'h12AF, -1, 16'h0, 4'h0);
    run_frame("f1_12af",   24, 1'b1, 1'b1, c_s12af, 4'b1111, 4'b0000, 5, 16'h0005, 15, 16'h0007, 4'h0);
    run_frame("f2_lz7",    24, 1'b1, 1'b1, c_s7lz,  4'b0001, 4'b0000, -1, 16'h0, -1, 16'h0, 4'h0);
    run_frame("f3_nolz7",  24, 1'b1, 1'b0, c_s0007, 4'b1111, 4'b0000, 23, 16'h8888, -1, 16'h0, 4'h0);
    run_frame("f4_8888",   24, 1'b1, 1'b0, c_s8888, 4'b1111, 4'b0000, -1, 16'h0, -1, 16'h0, 4'h0);
    run_frame("f5_hold",   24, 1'b1, 1'b0, c_s8888, 4'b1111, 4'b0000, 3, 16'h0000, -1, 16'h0, 4'b0100);
    run_frame("f6_lzdp",   24, 1'b1, 1'b1, c_s0lz,  4'b0101, 4'b0100, -1, 16'h0, -1, 16'h0, 4'h0);
    run_frame("f7_pre",    16, 1'b1, 1'b1, c_s0lz,  4'b0101, 4'b0100, 2, 16'h1234, -1, 16'h0, 4'b1111);

    // One-cycle reset pulse during digit 2 DWELL, with 16'h1234 pending.
    rst_n = 1'b0;
    step();
    chk("midrst an",   32'(bus.an),         32'h0000000F);
    chk("midrst seg",  32'(bus.seg),        32'h00000000);
    chk("midrst dp",   32'(bus.dp),         32'h00000000);
    chk("midrst tick", 32'(bus.frame_tick), 32'h00000000);
    rst_n = 1'b1;

    run_frame("f8_rst",    24, 1'b0, 1'b0, c_s0000, 4'b1111, 4'b0000, -1, 16'h0, -1, 16'h0, 4'h0);
    run_frame("f9_nopend", 24, 1'b1, 1'b0, c_s0000, 4'b1111, 4'b0000, -1, 16'h0, -1, 16'h0, 4'h0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
`default_nettype wire
